// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered divided clock plus a one-cycle tick
// in the last cycle of each period. Divisor changes take effect at period boundaries.
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic             div_load_i,
   output logic             clk_o,
   output logic             tick_o,
   output logic [WIDTH-1:0] active_div_o
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

   logic [WIDTH-1:0] pending_reg;
   logic [WIDTH-1:0] active_reg;
   logic [WIDTH-1:0] cnt_reg;
   logic             clk_reg;
   logic             tick_reg;

   logic             wrap;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] div_next;
   logic [WIDTH-1:0] idle_div;
   logic             clk_next;
   logic             tick_next;

   // Divisors 0 and 1 behave as 2; applied whenever a value enters the active register.
   function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
      return (v < TWO) ? TWO : v;
   endfunction

   always_comb begin
      wrap      = (cnt_reg == (active_reg - ONE));
      cnt_next  = wrap ? '0 : (cnt_reg + ONE);
      // A load coinciding with the wrap bypasses the pending register.
      div_next  = wrap ? clamp_div(div_load_i ? div_i : pending_reg) : active_reg;
      idle_div  = clamp_div(pending_reg);
      clk_next  = (cnt_next < (div_next >> 1));
      tick_next = (cnt_next == (div_next - ONE));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_reg <= DEF_DIV;
         active_reg  <= DEF_DIV;
         cnt_reg     <= DEF_DIV - ONE;
         clk_reg     <= 1'b0;
         tick_reg    <= 1'b0;
      end else begin
         if (div_load_i) begin
            pending_reg <= div_i;
         end
         if (!en_i) begin
            // Parking cnt at the last count makes the first enabled edge start a period.
            active_reg <= idle_div;
            cnt_reg    <= idle_div - ONE;
            clk_reg    <= 1'b0;
            tick_reg   <= 1'b0;
         end else begin
            active_reg <= div_next;
            cnt_reg    <= cnt_next;
            clk_reg    <= clk_next;
            tick_reg   <= tick_next;
         end
      end
   end

   assign clk_o        = clk_reg;
   assign tick_o       = tick_reg;
   assign active_div_o = active_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized and directed bench for clk_div_prog against a period-position model.
module tb_clk_div_prog;

   localparam int WIDTH = 8;
   localparam int DEF   = 2;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             en_i = 1'b0;
   logic [WIDTH-1:0] div_i = '0;
   logic             div_load_i = 1'b0;
   logic             clk_o;
   logic             tick_o;
   logic [WIDTH-1:0] active_div_o;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: position within the current period and the divisor of that period.
   int m_pend, m_act, m_pos;
   bit m_run, m_clk, m_tick;

   clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (en_i),
      .div_i        (div_i),
      .div_load_i   (div_load_i),
      .clk_o        (clk_o),
      .tick_o       (tick_o),
      .active_div_o (active_div_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int clampd(input int v);
      return (v < 2) ? 2 : v;
   endfunction

   task automatic model_reset();
      m_pend = DEF; m_act = DEF; m_pos = 0;
      m_run = 0; m_clk = 0; m_tick = 0;
   endtask

   task automatic model_edge(input bit en, input bit ld, input int d);
      int new_pend;
      new_pend = ld ? d : m_pend;
      if (!en) begin
         m_act = clampd(m_pend);
         m_run = 0; m_clk = 0; m_tick = 0;
      end else begin
         if (!m_run || m_pos == m_act - 1) begin
            m_act = clampd(ld ? d : m_pend);
            m_pos = 0;
            m_run = 1;
         end else begin
            m_pos++;
         end
         m_clk  = (m_pos < m_act / 2);
         m_tick = (m_pos == m_act - 1);
      end
      m_pend = new_pend;
   endtask

   task automatic check_outputs();
      check("clk_o", int'(clk_o), int'(m_clk));
      check("tick_o", int'(tick_o), int'(m_tick));
      check("active_div_o", int'(active_div_o), m_act);
   endtask

   // Drive inputs, take one edge, advance the model, compare 1 ns later.
   task automatic step(input bit en, input bit ld, input int d);
      en_i = en; div_load_i = ld; div_i = WIDTH'(d);
      @(posedge clk_i);
      model_edge(en, ld, d);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [4:0] clk_pat;
      logic [4:0] tick_pat;
      model_reset();
      #12;
      check("reset_clk", int'(clk_o), 0);
      check("reset_tick", int'(tick_o), 0);
      check("reset_active", int'(active_div_o), DEF);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Default divide-by-2 free run
      for (int i = 0; i < 8; i++) step(1, 0, 0);

      // Load 5 while idle, then run: 1,1,0,0,0 with tick on the 5th cycle
      step(0, 1, 5);
      step(0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0);
         clk_pat[4-i]  = clk_o;
         tick_pat[4-i] = tick_o;
      end
      check("div5_clk_pattern", int'(clk_pat), 5'b11000);
      check("div5_tick_pattern", int'(tick_pat), 5'b00001);
      check("div5_active", int'(active_div_o), 5);
      for (int i = 0; i < 10; i++) step(1, 0, 0);

      // Running at 4, load 6 mid-period
      step(0, 1, 4);
      step(1, 0, 0);
      step(1, 1, 6);
      check("div4_hold_active", int'(active_div_o), 4);
      for (int i = 0; i < 14; i++) step(1, 0, 0);
      check("div6_active", int'(active_div_o), 6);

      // Clamping of 0 and 1
      step(1, 1, 0);
      for (int i = 0; i < 8; i++) step(1, 0, 0);
      check("div0_active", int'(active_div_o), 2);
      step(1, 1, 1);
      for (int i = 0; i < 6; i++) step(1, 0, 0);

      // Load coinciding with a wrap bypasses pending
      step(1, 1, 3);
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      while (!(tick_o === 1'b0 && m_pos == m_act - 2)) step(1, 0, 0);
      step(1, 1, 7);
      step(1, 0, 0);

      // Disable mid-period at div 7, re-enable: full 3-high/4-low period
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      for (int i = 0; i < 9; i++) step(1, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit en, ld;
         int d;
         en = ($urandom_range(0, 9) != 0);
         ld = ($urandom_range(0, 4) == 0);
         d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
         step(en, ld, d);
      end

      // Asynchronous reset between edges while running div 9
      step(1, 1, 9);
      for (int i = 0; i < 12; i++) step(1, 0, 0);
      while (clk_o !== 1'b1 && m_act == 9) step(1, 0, 0);
      #2;
      rst_ni = 1'b0;
      model_reset();
      #1;
      check("async_clk", int'(clk_o), 0);
      check("async_tick", int'(tick_o), 0);
      check("async_active", int'(active_div_o), DEF);
      #1;
      rst_ni = 1'b1;
      for (int i = 0; i < 6; i++) step(1, 0, 0);
      check("post_reset_active", int'(active_div_o), DEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
